gmac_tx_framer: RTL

//  GMII transmit framer on the TX clock domain, directly downstream of the TX async FIFO read port.

---
 rtl/gmac_tx_framer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/gmac_tx_framer.sv
// gmac_tx_framer: GMII TX framer adding preamble/SFD, zero padding, CRC-32 FCS and inter-frame gap
module gmac_tx_framer #(
  parameter int unsigned PREAMBLE_BYTES = 7,
  parameter int unsigned MIN_FRAME      = 60,
  parameter int unsigned IFG_BYTES      = 12
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);
  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, DROP, PAD, FCS, IFG} state_t;
  state_t      state;
  logic [31:0] crc;
  logic [31:0] cnt;
  logic [15:0] byte_cnt;
  logic [15:0] byte_nxt;
  logic [7:0]  fcs_byte;
  logic        short_frame;
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  assign s_ready     = state == DATA || state == DROP;
  assign busy        = state != IDLE;
  assign byte_nxt    = byte_cnt == 16'hFFFF ? byte_cnt : byte_cnt + 16'd1;
  assign short_frame = {16'd0, byte_cnt} + 32'd1 < MIN_FRAME;
  assign fcs_byte    = ~crc[{cnt[1:0], 3'b000} +: 8];
  // Outputs default to an idle line each cycle; states override what they drive.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state      <= IDLE;
      crc        <= 32'hFFFFFFFF;
      cnt        <= '0;
      byte_cnt   <= '0;
      gmii_txd   <= '0;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      gmii_txd   <= 8'h00;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      case (state)
        IDLE: if (s_valid) begin
          gmii_txd   <= 8'h55;
          gmii_tx_en <= 1'b1;
          crc        <= 32'hFFFFFFFF;
          cnt        <= 32'd1;
          byte_cnt   <= '0;
          if (PREAMBLE_BYTES > 1) state <= PRE;
          else state <= SFD;
        end
        PRE: begin
          gmii_txd   <= 8'h55;
          gmii_tx_en <= 1'b1;
          cnt        <= cnt + 32'd1;
          if (cnt + 32'd1 >= PREAMBLE_BYTES) state <= SFD;
        end
        SFD: begin
          gmii_txd   <= 8'hD5;
          gmii_tx_en <= 1'b1;
          state      <= DATA;
        end
        DATA: if (s_valid) begin
          gmii_txd   <= s_data;
          gmii_tx_en <= 1'b1;
          crc        <= crc_upd(crc, s_data);
          byte_cnt   <= byte_nxt;
          cnt        <= '0;
          if (s_last) begin
            if (short_frame) state <= PAD;
            else state <= FCS;
          end
        end else begin
          gmii_tx_en <= 1'b1;
          gmii_tx_er <= 1'b1;
          underrun   <= 1'b1;
          state      <= DROP;
        end
        DROP: if (s_valid && s_last) begin
          cnt   <= '0;
          state <= IFG;
        end
        PAD: begin
          gmii_tx_en <= 1'b1;
          crc        <= crc_upd(crc, 8'h00);
          byte_cnt   <= byte_nxt;
          cnt        <= '0;
          if (!short_frame) state <= FCS;
        end
        FCS: begin
          gmii_txd   <= fcs_byte;
          gmii_tx_en <= 1'b1;
          cnt        <= cnt + 32'd1;
          if (cnt[1:0] == 2'd3) begin
            frame_done <= 1'b1;
            cnt        <= '0;
            state      <= IFG;
          end
        end
        IFG: begin
          cnt <= cnt + 32'd1;
          if (cnt + 32'd1 >= IFG_BYTES) state <= IDLE;
        end
      endcase
    end
endmodule
